data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving the number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request acceptance and response (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid, input, 1 bit: the processor presents a load or store.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3 bits: RISC-V size/sign code (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu).
REQ-011 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the processor takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load data after extension; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1 bit: access faulted (misaligned or illegal funct3).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL, in IDLE with req_valid=1, latch write, addr, wdata and funct3, load a counter with LATENCY-1, and enter WAIT.
REQ-017 SHALL decrement the counter each cycle in WAIT and move to RESP when the counter is 0, so rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
REQ-018 SHALL commit a store to storage on the WAIT->RESP edge, using byte enables derived from funct3 and addr[1:0]; untouched bytes keep their value.
REQ-019 SHALL sample the load word on the WAIT->RESP edge, shift it by addr[1:0], then sign- or zero-extend it per funct3 into rsp_rdata.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-021 SHALL not accept a new request in the cycle of RESP->IDLE (req_ready still 0), giving at most one outstanding access.
REQ-022 SHALL index storage with addr[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around).
REQ-023 SHALL treat funct3 011, 110 and 111 as illegal: rsp_err=1, rdata=0, no write.
REQ-024 SHALL deassert rsp_valid, rsp_err and set rsp_rdata=0 in IDLE and WAIT.

Reset
REQ-025 SHALL, while reset=0, force the FSM to IDLE, counter to 0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=1 after release.
REQ-026 SHALL, on reset asserted in WAIT, abort the access without writing storage.
REQ-027 SHALL leave storage contents unchanged by reset.

Configuration
REQ-028 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag halfword access with addr[0]=1 and word access with addr[1:0]!=0 as rsp_err=1, rdata=0, no write.
REQ-029 SHALL, without DMEM_MISALIGN_CHECK_EN, force the offending low address bits to 0 and complete the access normally with rsp_err=0.

Structure
REQ-030 SHALL take funct3 size codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding from the shared processor package.
REQ-031 SHALL place byte-lane alignment and extension in one combinational sub-module, load_store_align, shared for store lane placement and load extraction.

Verification
REQ-032 SHALL test sw addr 0x8 data 0xDEADBEEF, then lw addr 0x8 -> rsp_rdata 0xDEADBEEF, rsp_valid at accept+LATENCY+1, rsp_err 0.
REQ-033 SHALL test sb 0x80 to addr 0x9 over 0xDEADBEEF, then lb 0x9 -> 0xFFFFFF80, lbu 0x9 -> 0x00000080, lw 0x8 -> 0xDEAD80EF.
REQ-034 SHALL test holding rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-035 SHALL test lw addr 0x6 -> rsp_err 1 with macro defined; data from word 0x4 with macro undefined.
REQ-036 SHALL test reset pulsed during WAIT of sw 0x11111111 to addr 0x10 -> later lw 0x10 returns the prior value.
REQ-037 SHALL test sw to addr 4*DEPTH -> lw addr 0x0 returns the stored value (wrap-around).

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// data_mem_responder_pkg : funct3 size codes, FSM encoding and helpers shared
// by the data-memory responder and its lane alignment logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_load_store_align.sv
// ============================================================================
// load_store_align : byte-lane placement for stores and lane extraction plus
// sign/zero extension for loads. Optional DMEM_MISALIGN_CHECK_EN faults
// misaligned halfword/word accesses instead of truncating the offset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wlane_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [1:0]  w_off;
    logic [3:0]  w_be_base;
    logic [4:0]  w_sh;
    logic [31:0] w_shifted;
    logic        w_illegal;

    // Halfword/word offsets are forced onto their natural boundary.
    always_comb begin
        w_off     = 2'b00;
        w_be_base = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                w_off     = addr_i;
                w_be_base = 4'b0001;
            end
            2'b01: begin
                w_off     = {addr_i[1], 1'b0};
                w_be_base = 4'b0011;
            end
            default: ;
        endcase
    end

    assign w_illegal = f3_illegal(funct3_i);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                     || ((funct3_i[1:0] == 2'b10) && (addr_i != 2'b00));
    assign err_o = w_illegal | w_misalign;
`else
    assign err_o = w_illegal;
`endif

    assign w_sh      = {w_off, 3'b000};
    assign wlane_o   = wdata_i << w_sh;
    assign be_o      = err_o ? 4'b0000 : (w_be_base << w_off);
    assign w_shifted = rword_i >> w_sh;

    always_comb begin
        rdata_o = 32'h0;
        if (!err_o) begin
            case (funct3_i)
                F3_LB:   rdata_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
                F3_LH:   rdata_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
                F3_LW:   rdata_o = w_shifted;
                F3_LBU:  rdata_o = {24'h0, w_shifted[7:0]};
                F3_LHU:  rdata_o = {16'h0, w_shifted[15:0]};
                default: rdata_o = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : single-outstanding data memory with fixed latency,
// RISC-V byte/half/word access. Misalignment faulting via DMEM_MISALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e   state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_word_d;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_lane;
    logic [3:0]    w_be;
    logic [31:0]   w_ld_data;
    logic          w_err;
    logic          w_fire;
    logic          unused_addr_hi;

    // Address bits above the storage index wrap around by construction.
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign w_idx  = addr_q[AW+1:2];
    assign w_word = mem_q[w_idx];
    assign w_fire = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    load_store_align u_align (
        .funct3_i (funct3_q),
        .addr_i   (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rword_i  (w_word),
        .wlane_o  (w_lane),
        .be_o     (w_be),
        .rdata_o  (w_ld_data),
        .err_o    (w_err)
    );

    always_comb begin
        mem_word_d = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                mem_word_d[8*b +: 8] = w_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            funct3_q    <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr[AW+1:0];
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        cnt_q    <= CNT_INIT;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= w_err;
                        rsp_rdata_q <= write_q ? 32'h0 : w_ld_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Storage has no reset; an asynchronous reset drops the FSM out of WAIT
    // before the commit edge, so an interrupted store never lands.
    always_ff @(posedge clk) begin
        if (w_fire && write_q) begin
            mem_q[w_idx] <= mem_word_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : directed self-checking bench for data_mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;
    localparam int LIMIT   = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // lat counts rising edges from presenting the request (its accept edge
    // included) until rsp_valid is seen; LIMIT and X data mark a timeout.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f, output logic [31:0] rd,
                            output logic er, output int lat);
        rd  = 32'hx;
        er  = 1'bx;
        lat = LIMIT;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n < LIMIT; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(posedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00000000", rsp_rdata); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h8, 32'hDEADBEEF, 3'b010, rd, er, lat);
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LATENCY + 1); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=00000000", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", er); end
        transact(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", lat, LATENCY + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=DEADBEEF", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", er); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h9, 32'h00000080, 3'b000, rd, er, lat);
        transact(1'b0, 32'h9, 32'h0, 3'b000, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_9 got=%h exp=FFFFFF80", rd); end
        transact(1'b0, 32'h9, 32'h0, 3'b100, rd, er, lat);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_9 got=%h exp=00000080", rd); end
        transact(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        checks++; if (rd !== 32'hDEAD80EF) begin failures++; $display("FAIL lw_after_sb got=%h exp=DEAD80EF", rd); end
        transact(1'b1, 32'hA, 32'h00001234, 3'b001, rd, er, lat);
        transact(1'b1, 32'h8, 32'hABCDF00D, 3'b001, rd, er, lat);
        transact(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        checks++; if (rd !== 32'h1234F00D) begin failures++; $display("FAIL lw_after_sh got=%h exp=1234F00D", rd); end
        transact(1'b0, 32'hA, 32'h0, 3'b001, rd, er, lat);
        checks++; if (rd !== 32'h00001234) begin failures++; $display("FAIL lh_A got=%h exp=00001234", rd); end
        transact(1'b0, 32'h8, 32'h0, 3'b001, rd, er, lat);
        checks++; if (rd !== 32'hFFFFF00D) begin failures++; $display("FAIL lh_8 got=%h exp=FFFFF00D", rd); end
        transact(1'b0, 32'h8, 32'h0, 3'b101, rd, er, lat);
        checks++; if (rd !== 32'h0000F00D) begin failures++; $display("FAIL lhu_8 got=%h exp=0000F00D", rd); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat;
        transact(1'b0, 32'h8, 32'h0, 3'b011, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL illegal_load_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL illegal_load_rdata got=%h exp=00000000", rd); end
        transact(1'b1, 32'h8, 32'h55555555, 3'b111, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL illegal_store_err got=%b exp=1", er); end
        transact(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        checks++; if (rd !== 32'h1234F00D) begin failures++; $display("FAIL illegal_store_nowrite got=%h exp=1234F00D", rd); end
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h8;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_timeout rsp_valid got=%b exp=1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h1234F00D) begin failures++; $display("FAIL hold_rdata cyc=%0d got=%h exp=1234F00D", i, rsp_rdata); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h4, 32'hCAFEF00D, 3'b010, rd, er, lat);
        transact(1'b0, 32'h6, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misalign_rdata got=%h exp=00000000", rd); end
`else
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL misalign_err got=%b exp=0", er); end
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL misalign_rdata got=%h exp=CAFEF00D", rd); end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h10, 32'hA5A5A5A5, 3'b010, rd, er, lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'h11111111;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
        repeat (4) @(negedge clk);
        transact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL abort_nowrite got=%h exp=A5A5A5A5", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'(4 * DEPTH), 32'h0BADF00D, 3'b010, rd, er, lat);
        transact(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL wrap_lw0 got=%h exp=0BADF00D", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_illegal();
        test_hold();
        test_misalign();
        test_reset_abort();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
